mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// Control FSM for a multicycle MIPS-subset datapath.
// Decodes the IR fields into datapath selects and one-cycle write/access strobes.
module mc_controller #(
   parameter int unsigned MD_LAT   = 8,
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic [4:0] rt,
   input  logic       zero,
   input  logic       sign,
   input  logic       mem_ready,
   output logic       PCWr,
   output logic       IRWr,
   output logic       RegWr,
   output logic       MemRd,
   output logic       MemWr,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic [4:0] ALUctr,
   output logic [1:0] NPCop,
   output logic       ExtOp,
   output logic       MDstart,
   output logic       illegal,
   output logic       busy,
   output logic [3:0] state
);

   localparam int unsigned CNT_W = 8;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_EXE    = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_WB     = 4'd6;
   localparam logic [3:0] S_BRANCH = 4'd7;
   localparam logic [3:0] S_JUMP   = 4'd8;
   localparam logic [3:0] S_MDWAIT = 4'd9;

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_AND  = 5'd2;
   localparam logic [4:0] ALU_OR   = 5'd3;
   localparam logic [4:0] ALU_SLT  = 5'd4;
   localparam logic [4:0] ALU_SLTU = 5'd5;
   localparam logic [4:0] ALU_LUI  = 5'd6;
   localparam logic [4:0] ALU_SLL  = 5'd7;

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic is_r, r_alu, r_jr, r_jalr, r_mf, r_md;
   logic i_lw, i_sw, i_beq, i_bne, i_regimm, i_bltz, i_bgez;
   logic i_addiu, i_ori, i_lui, i_j, i_jal;
   logic c_mem, c_br, c_jmp, c_md, c_exe, legal;
   logic mem_done, br_take;
   logic pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, md_start, ill;

   // Instruction class decode from the current IR fields
   assign is_r     = (op == 6'h00);
   assign r_alu    = is_r && (func == 6'h21 || func == 6'h23 || func == 6'h24 || func == 6'h25 ||
                              func == 6'h2A || func == 6'h2B || func == 6'h00);
   assign r_jr     = is_r && (func == 6'h08);
   assign r_jalr   = is_r && (func == 6'h09);
   assign r_mf     = is_r && (func == 6'h10 || func == 6'h12);
   assign r_md     = is_r && (func == 6'h18 || func == 6'h19 || func == 6'h1A || func == 6'h1B);
   assign i_lw     = (op == 6'h23);
   assign i_sw     = (op == 6'h2B);
   assign i_beq    = (op == 6'h04);
   assign i_bne    = (op == 6'h05);
   assign i_regimm = (op == 6'h01);
   assign i_bltz   = i_regimm && (rt == 5'd0);
   assign i_bgez   = i_regimm && (rt == 5'd1);
   assign i_addiu  = (op == 6'h09);
   assign i_ori    = (op == 6'h0D);
   assign i_lui    = (op == 6'h0F);
   assign i_j      = (op == 6'h02);
   assign i_jal    = (op == 6'h03);

   assign c_mem = i_lw || i_sw;
   assign c_br  = i_beq || i_bne || i_bltz || i_bgez;
   assign c_jmp = i_j || i_jal || r_jr || r_jalr;
   assign c_md  = r_md;
   assign c_exe = r_alu || r_mf || i_addiu || i_ori || i_lui;
   assign legal = c_mem || c_br || c_jmp || c_md || c_exe;

   assign mem_done = mem_ready || (MEM_WAIT == 0);
   assign br_take  = (i_beq && zero) || (i_bne && !zero) || (i_bltz && sign) || (i_bgez && !sign);

   // State and multiply/divide residency counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = S_FETCH;
      cnt_d   = cnt_q;
      case (state_q)
         S_FETCH:  state_d = mem_done ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (c_mem)      state_d = S_MEMADR;
            else if (c_br)  state_d = S_BRANCH;
            else if (c_jmp) state_d = S_JUMP;
            else if (c_md) begin
               state_d = S_MDWAIT;
               cnt_d   = CNT_W'(MD_LAT - 1);
            end
            else if (c_exe) state_d = S_EXE;
            else            state_d = S_FETCH;
         end
         S_EXE:    state_d = S_WB;
         S_MEMADR: state_d = i_lw ? S_MEMRD : S_MEMWR;
         S_MEMRD,
         S_MEMWR:  state_d = mem_done ? S_FETCH : state_q;
         S_MDWAIT: begin
            if (cnt_q == '0) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_MDWAIT;
               cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         default:  state_d = S_FETCH;
      endcase
   end

   // Output decode: registered state plus mem_ready/zero/sign
   always_comb begin
      pc_wr    = 1'b0;
      ir_wr    = 1'b0;
      reg_wr   = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      md_start = 1'b0;
      ill      = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'd0;
      RegDst   = 2'd0;
      MemtoReg = 2'd0;
      ALUctr   = ALU_ADD;
      NPCop    = 2'd0;
      ExtOp    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_rd  = 1'b1;
            ALUSrcB = 2'd1;
            if (mem_done) begin
               pc_wr = 1'b1;
               ir_wr = 1'b1;
            end
         end
         S_DECODE: begin
            ALUSrcB  = 2'd3;
            ExtOp    = 1'b1;
            md_start = c_md;
            ill      = !legal;
         end
         S_EXE: begin
            ALUSrcA = 1'b1;
            if (is_r) begin
               ALUSrcB = 2'd0;
               case (func)
                  6'h23:   ALUctr = ALU_SUB;
                  6'h24:   ALUctr = ALU_AND;
                  6'h25:   ALUctr = ALU_OR;
                  6'h2A:   ALUctr = ALU_SLT;
                  6'h2B:   ALUctr = ALU_SLTU;
                  6'h00:   ALUctr = ALU_SLL;
                  default: ALUctr = ALU_ADD;
               endcase
            end else begin
               ALUSrcB = 2'd2;
               ExtOp   = i_addiu;
               if (i_ori)      ALUctr = ALU_OR;
               else if (i_lui) ALUctr = ALU_LUI;
               else            ALUctr = ALU_ADD;
            end
         end
         S_WB: begin
            reg_wr   = 1'b1;
            RegDst   = is_r ? 2'd1 : 2'd0;
            MemtoReg = r_mf ? 2'd3 : 2'd0;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            ExtOp   = 1'b1;
         end
         S_MEMRD: begin
            mem_rd = 1'b1;
            if (mem_done) begin
               reg_wr   = 1'b1;
               MemtoReg = 2'd1;
            end
         end
         S_MEMWR:  mem_wr = 1'b1;
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            ALUctr  = i_regimm ? ALU_SLT : ALU_SUB;
            if (br_take) begin
               pc_wr = 1'b1;
               NPCop = 2'd1;
            end
         end
         S_JUMP: begin
            pc_wr = 1'b1;
            NPCop = (r_jr || r_jalr) ? 2'd3 : 2'd2;
            if (i_jal) begin
               reg_wr   = 1'b1;
               RegDst   = 2'd2;
               MemtoReg = 2'd2;
            end else if (r_jalr) begin
               reg_wr   = 1'b1;
               RegDst   = 2'd1;
               MemtoReg = 2'd2;
            end
         end
         default: ;
      endcase
   end

   // Reset suppresses every strobe; only the FETCH read stays visible
   assign PCWr    = rst && pc_wr;
   assign IRWr    = rst && ir_wr;
   assign RegWr   = rst && reg_wr;
   assign MemWr   = rst && mem_wr;
   assign MDstart = rst && md_start;
   assign illegal = rst && ill;
   assign MemRd   = mem_rd && (rst || state_q == S_FETCH);
   assign busy    = (state_q != S_FETCH);
   assign state   = state_q;

endmodule
